hwpe_ctrl_offload_master: RTL and testbench

Initiator side of the HWPE peripheral control protocol. It offloads one job to an HWPE control slave and then waits for completion:
- reads the ACQUIRE register and retries with backoff while the slave is busy;
- writes N_JOB_REGS job registers, then writes TRIGGER;
- waits for the completion event and reports the acquired job ID.
Used by a controlling engine or testbench-replacement sequencer.

---
 rtl/hwpe_ctrl_offload_master.sv | 224 ++++++++++++++++++++++
 tb/tb_hwpe_ctrl_offload_master.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_offload_master.sv
// rtl/hwpe_ctrl_offload_master.sv - HWPE control initiator: acquire with backoff, job register writes, trigger, completion wait
module hwpe_ctrl_offload_master #(
    parameter int          N_JOB_REGS     = 4,
    parameter logic [31:0] JOB_BASE_ADDR  = 32'h40,
    parameter logic [31:0] ACQUIRE_ADDR   = 32'h04,
    parameter logic [31:0] TRIGGER_ADDR   = 32'h00,
    parameter int          BACKOFF_CYCLES = 8,
    parameter int          MAX_RETRIES    = 15,
    parameter int          ID_WIDTH       = 16,
    parameter int          CORE_ID        = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [N_JOB_REGS*32-1:0] job_regs_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [7:0]              job_id_o,
    input  logic                    evt_i,
    output logic                    req_o,
    output logic [31:0]             add_o,
    output logic                    wen_o,
    output logic [3:0]              be_o,
    output logic [31:0]             data_o,
    output logic [ID_WIDTH-1:0]     id_o,
    input  logic                    gnt_i,
    input  logic [31:0]             r_data_i,
    input  logic                    r_valid_i,
    input  logic [ID_WIDTH-1:0]     r_id_i
);
    localparam int KW = $clog2(N_JOB_REGS) + 1;
    localparam int RW = $clog2(MAX_RETRIES + 2);
    localparam int BW = $clog2(BACKOFF_CYCLES + 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ACQ_REQ  = 4'd1;
    localparam logic [3:0] S_ACQ_RSP  = 4'd2;
    localparam logic [3:0] S_BACKOFF  = 4'd3;
    localparam logic [3:0] S_WR_REQ   = 4'd4;
    localparam logic [3:0] S_WR_RSP   = 4'd5;
    localparam logic [3:0] S_TRG_REQ  = 4'd6;
    localparam logic [3:0] S_TRG_RSP  = 4'd7;
    localparam logic [3:0] S_WAIT_EVT = 4'd8;

    logic [3:0]               state_q, state_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic [7:0]               job_id_q, job_id_d;
    logic                     req_q, req_d;
    logic [31:0]              add_q, add_d;
    logic                     wen_q, wen_d;
    logic [31:0]              data_q, data_d;
    logic [RW-1:0]            retry_q, retry_d;
    logic [BW-1:0]            bo_q, bo_d;
    logic [KW-1:0]            k_q, k_d;
    logic [N_JOB_REGS*32-1:0] job_q, job_d;
    logic                     evt_latch_q, evt_latch_d;

    logic                     rsp_ok;
    logic [KW-1:0]            k_inc;
    logic [31:0]              next_word;
    logic                     unused_rdata;

    assign rsp_ok       = r_valid_i && (r_id_i == ID_WIDTH'(CORE_ID));
    assign k_inc        = k_q + 1'b1;
    assign unused_rdata = ^r_data_i[30:8];

    always_comb begin
        next_word = '0;
        for (int i = 0; i < N_JOB_REGS; i++) begin
            if (k_inc == KW'(i)) next_word = job_q[i*32 +: 32];
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        job_id_d    = job_id_q;
        req_d       = req_q;
        add_d       = add_q;
        wen_d       = wen_q;
        data_d      = data_q;
        retry_d     = retry_q;
        bo_d        = bo_q;
        k_d         = k_q;
        job_d       = job_q;
        evt_latch_d = evt_latch_q;
        case (state_q)
            S_IDLE: begin
                // done_q high means this cycle is the completion pulse; a start here is dropped
                if (start_i && !done_q) begin
                    state_d = S_ACQ_REQ;
                    job_d   = job_regs_i;
                    busy_d  = 1'b1;
                    retry_d = '0;
                    req_d   = 1'b1;
                    add_d   = ACQUIRE_ADDR;
                    wen_d   = 1'b1;
                end
            end
            S_ACQ_REQ: if (gnt_i) begin
                req_d   = 1'b0;
                state_d = S_ACQ_RSP;
            end
            S_ACQ_RSP: if (rsp_ok) begin
                if (r_data_i[31]) begin
                    if (retry_q == RW'(MAX_RETRIES)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        bo_d    = '0;
                        state_d = S_BACKOFF;
                    end
                end else begin
                    job_id_d = r_data_i[7:0];
                    k_d      = '0;
                    state_d  = S_WR_REQ;
                    req_d    = 1'b1;
                    add_d    = JOB_BASE_ADDR;
                    data_d   = job_q[31:0];
                    wen_d    = 1'b0;
                end
            end
            S_BACKOFF: begin
                if (bo_q == BW'(BACKOFF_CYCLES - 1)) begin
                    state_d = S_ACQ_REQ;
                    req_d   = 1'b1;
                    add_d   = ACQUIRE_ADDR;
                    wen_d   = 1'b1;
                end else begin
                    bo_d = bo_q + 1'b1;
                end
            end
            S_WR_REQ: if (gnt_i) begin
                req_d   = 1'b0;
                state_d = S_WR_RSP;
            end
            S_WR_RSP: if (rsp_ok) begin
                req_d = 1'b1;
                wen_d = 1'b0;
                if (k_q == KW'(N_JOB_REGS - 1)) begin
                    state_d = S_TRG_REQ;
                    add_d   = TRIGGER_ADDR;
                    data_d  = '0;
                end else begin
                    k_d     = k_inc;
                    state_d = S_WR_REQ;
                    add_d   = JOB_BASE_ADDR + (32'(k_inc) << 2);
                    data_d  = next_word;
                end
            end
            S_TRG_REQ: if (gnt_i) begin
                // events before this grant belong to a stale job; arm from here on
                req_d       = 1'b0;
                evt_latch_d = evt_i;
                state_d     = S_TRG_RSP;
            end
            S_TRG_RSP: begin
                evt_latch_d = evt_latch_q | evt_i;
                if (rsp_ok) state_d = S_WAIT_EVT;
            end
            S_WAIT_EVT: if (evt_i || evt_latch_q) begin
                state_d     = S_IDLE;
                done_d      = 1'b1;
                error_d     = 1'b0;
                busy_d      = 1'b0;
                evt_latch_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            job_id_q    <= '0;
            req_q       <= 1'b0;
            add_q       <= '0;
            wen_q       <= 1'b1;
            data_q      <= '0;
            retry_q     <= '0;
            bo_q        <= '0;
            k_q         <= '0;
            job_q       <= '0;
            evt_latch_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            job_id_q    <= job_id_d;
            req_q       <= req_d;
            add_q       <= add_d;
            wen_q       <= wen_d;
            data_q      <= data_d;
            retry_q     <= retry_d;
            bo_q        <= bo_d;
            k_q         <= k_d;
            job_q       <= job_d;
            evt_latch_q <= evt_latch_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign error_o  = error_q;
    assign job_id_o = job_id_q;
    assign req_o    = req_q;
    assign add_o    = add_q;
    assign wen_o    = wen_q;
    assign data_o   = data_q;
    assign be_o     = 4'hF;
    assign id_o     = ID_WIDTH'(CORE_ID);
endmodule

// File: tb/tb_hwpe_ctrl_offload_master.sv
// tb/tb_hwpe_ctrl_offload_master.sv - scripted slave, transaction-list model and scenario table for the offload master
module tb_hwpe_ctrl_offload_master;
    localparam int          N    = 4;
    localparam int          MAXR = 15;
    localparam int          BO   = 8;
    localparam logic [31:0] JB   = 32'h40;
    localparam logic [31:0] AQ   = 32'h04;
    localparam logic [31:0] TG   = 32'h00;
    localparam logic [15:0] CID  = 16'd0;

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    logic           start_i = 1'b0;
    logic [N*32-1:0] job_regs_i = '0;
    logic           evt_i = 1'b0;
    logic           gnt_i = 1'b0;
    logic [31:0]    r_data_i = '0;
    logic           r_valid_i = 1'b0;
    logic [15:0]    r_id_i = '0;
    logic           busy_o, done_o, error_o, req_o, wen_o;
    logic [7:0]     job_id_o;
    logic [31:0]    add_o, data_o;
    logic [3:0]     be_o;
    logic [15:0]    id_o;

    hwpe_ctrl_offload_master dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .job_regs_i(job_regs_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .job_id_o(job_id_o),
        .evt_i(evt_i), .req_o(req_o), .add_o(add_o), .wen_o(wen_o), .be_o(be_o),
        .data_o(data_o), .id_o(id_o), .gnt_i(gnt_i), .r_data_i(r_data_i),
        .r_valid_i(r_valid_i), .r_id_i(r_id_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec = 0;
    int mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;
    txn_t seen[$];
    txn_t exp_q[$];
    logic [31:0] acq_vals[$];

    // Expected bus transactions derived from the protocol rules alone
    function automatic void model(input logic [N*32-1:0] jobs, input int n_busy,
                                  output bit err, output int reads);
        exp_q.delete();
        err   = n_busy > MAXR;
        reads = err ? MAXR + 1 : n_busy + 1;
        for (int i = 0; i < reads; i++) exp_q.push_back('{1'b1, AQ, 32'h0});
        if (!err) begin
            for (int i = 0; i < N; i++) exp_q.push_back('{1'b0, JB + 32'(4 * i), jobs[i*32 +: 32]});
            exp_q.push_back('{1'b0, TG, 32'h0});
        end
    endfunction

    // Slave behaviour knobs and bookkeeping
    int          wait_left = -1, rsp_dly = 0, low_run = 0, wr_idx = 0, evt_cnt = 0;
    int          s_k = -1, s_len = 0, em = 1, wr_dly = 0;
    int          evt_cyc = -1, trg_rsp_cyc = -1;
    bit          pend = 0, pend_rd = 0, pend_trg = 0, count_low = 0, rt = 0, manual_evt = 0, w1_flag = 0;
    logic [31:0] pend_data = '0, st_add = '0, st_data = '0;
    logic        st_wen = 1'b0;

    always @(negedge clk) begin
        gnt_i = 1'b0; r_valid_i = 1'b0; r_id_i = CID; r_data_i = '0; evt_i = 1'b0;
        if (!rst_ni) begin
            pend = 0; wait_left = -1; evt_cnt = 0; count_low = 0;
        end else begin
            if (pend) begin
                if (rsp_dly > 0) begin
                    rsp_dly--;
                    if (rt && $urandom_range(1, 0) == 1) begin
                        r_valid_i = 1'b1; r_id_i = CID + 16'd1; r_data_i = $urandom;
                    end
                end else begin
                    r_valid_i = 1'b1; r_data_i = pend_data; pend = 0;
                    if (pend_rd && pend_data[31]) begin count_low = 1; low_run = 0; end
                    if (pend_trg) begin
                        trg_rsp_cyc = cyc;
                        if (em == 1) evt_cnt = $urandom_range(5, 2);
                    end
                end
            end else if (req_o) begin
                if (wait_left < 0) begin
                    st_add = add_o; st_data = data_o; st_wen = wen_o;
                    if (rt) wait_left = $urandom_range(3, 0);
                    else if (!wen_o && wr_idx == s_k) wait_left = s_len;
                    else wait_left = 0;
                    if (wen_o && count_low) begin
                        check("backoff_gap", low_run, BO);
                        count_low = 0;
                    end
                end else begin
                    check("hold_add", add_o, st_add);
                    check("hold_data", data_o, st_data);
                    check("hold_wen", wen_o, st_wen);
                end
                if (wait_left == 0) begin
                    gnt_i = 1'b1;
                    seen.push_back('{wen_o, add_o, data_o});
                    pend = 1; wait_left = -1;
                    pend_rd  = wen_o;
                    pend_trg = !wen_o && add_o == TG && wr_idx >= N;
                    rsp_dly  = rt ? $urandom_range(3, 0) : (!wen_o ? wr_dly : 0);
                    if (wen_o) pend_data = (acq_vals.size() > 0) ? acq_vals.pop_front() : 32'hFFFF_FFFF;
                    else begin
                        pend_data = $urandom;
                        if (wr_idx == 1) begin
                            w1_flag = 1;
                            if (em == 2 || em == 3) evt_i = 1'b1;
                        end
                        if (pend_trg && em == 2) evt_i = 1'b1;
                        wr_idx++;
                    end
                end else begin
                    wait_left--;
                end
            end else if (count_low) begin
                low_run++;
            end
            if (evt_cnt > 0) begin
                evt_cnt--;
                if (evt_cnt == 0) begin evt_i = 1'b1; evt_cyc = cyc; end
            end
            if (manual_evt) begin evt_i = 1'b1; evt_cyc = cyc; manual_evt = 0; end
        end
    end

    task automatic start_job(input logic [N*32-1:0] jobs, input int n_busy, input logic [31:0] free_v);
        seen.delete(); acq_vals.delete();
        for (int i = 0; i < n_busy; i++) acq_vals.push_back(32'hFFFF_FFFF);
        acq_vals.push_back(free_v);
        wait_left = -1; wr_idx = 0; count_low = 0; w1_flag = 0;
        evt_cyc = -1; trg_rsp_cyc = -1; evt_cnt = 0; manual_evt = 0;
        @(negedge clk); start_i = 1'b1; job_regs_i = jobs;
        @(negedge clk); start_i = 1'b0; job_regs_i = ~jobs;
        check("busy_after_start", busy_o, 1'b1);
    endtask

    task automatic run_job(input logic [N*32-1:0] jobs, input int n_busy, input logic [31:0] free_v,
                           output bit err, output logic [7:0] id, output int reads, output int writes);
        bit exp_err;
        int exp_reads;
        bit got = 0;
        int t = 0, done_cyc = 0, man_t = -1, n;
        err = 0; id = '0; reads = 0; writes = 0;
        model(jobs, n_busy, exp_err, exp_reads);
        start_job(jobs, n_busy, free_v);
        @(negedge clk); start_i = 1'b1; job_regs_i = ~jobs;
        @(negedge clk); start_i = 1'b0;
        while (!got && t < 3000) begin
            @(negedge clk); t++;
            if (done_o) begin
                got = 1; done_cyc = cyc; err = error_o; id = job_id_o;
                check("busy_at_done", busy_o, 1'b0);
            end else if (em == 3 && trg_rsp_cyc >= 0 && man_t < 0 && cyc >= trg_rsp_cyc + 40) begin
                manual_evt = 1; man_t = cyc;
            end
        end
        check("done_seen", got, 1'b1);
        if (!got) begin
            @(posedge clk); #1 rst_ni = 1'b0;
            @(posedge clk); #1 rst_ni = 1'b1;
            return;
        end
        start_i = 1'b1; job_regs_i = ~jobs;
        @(negedge clk); start_i = 1'b0;
        check("done_width", done_o, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("start_during_done", {busy_o, req_o}, 2'b00);
        end
        n = (seen.size() < exp_q.size()) ? seen.size() : exp_q.size();
        check("n_txn", seen.size(), exp_q.size());
        for (int i = 0; i < n; i++) begin
            check("txn_wen", seen[i].wen, exp_q[i].wen);
            check("txn_addr", seen[i].addr, exp_q[i].addr);
            if (!exp_q[i].wen) check("txn_data", seen[i].data, exp_q[i].data);
        end
        foreach (seen[i]) if (seen[i].wen) reads++; else writes++;
        if (!exp_err) begin
            if (em == 1) check("evt_to_done", done_cyc, evt_cyc + 1);
            if (em == 2) check("trg_to_done", done_cyc, trg_rsp_cyc + 2);
            if (em == 3) check("stale_evt_ignored", man_t >= 0, 1'b1);
        end
    endtask

    typedef struct {
        int          n_busy;
        logic [31:0] free_v;
        int          s_k;
        int          s_len;
        int          em;
        bit          exp_err;
        logic [7:0]  exp_id;
        int          exp_reads;
        int          exp_writes;
    } scen_t;

    initial begin
        scen_t          tab[7];
        logic [N*32-1:0] jobs;
        bit             err, m_err;
        logic [7:0]     id;
        logic [31:0]    fv;
        int             reads, writes, m_reads, nb, t;

        tab[0] = '{0,  32'h0000_0001, -1, 0, 1, 1'b0, 8'h01, 1,  5};
        tab[1] = '{2,  32'h0000_0000, -1, 0, 1, 1'b0, 8'h00, 3,  5};
        tab[2] = '{16, 32'h0000_0000, -1, 0, 1, 1'b1, 8'h00, 16, 0};
        tab[3] = '{0,  32'h0000_00A5,  2, 5, 1, 1'b0, 8'hA5, 1,  5};
        tab[4] = '{0,  32'h0000_0007, -1, 0, 2, 1'b0, 8'h07, 1,  5};
        tab[5] = '{0,  32'h0000_0012, -1, 0, 3, 1'b0, 8'h12, 1,  5};
        tab[6] = '{15, 32'h0000_003C, -1, 0, 1, 1'b0, 8'h3C, 16, 5};

        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        check("rst_req", req_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_error", error_o, 1'b0);
        check("rst_job_id", job_id_o, 8'h00);
        check("rst_add", add_o, 32'h0);
        check("rst_data", data_o, 32'h0);
        check("rst_wen", wen_o, 1'b1);
        check("be_const", be_o, 4'hF);
        check("id_const", id_o, CID);

        foreach (tab[s]) begin
            for (int i = 0; i < N; i++) jobs[i*32 +: 32] = $urandom;
            s_k = tab[s].s_k; s_len = tab[s].s_len; em = tab[s].em; rt = 0; wr_dly = 0;
            run_job(jobs, tab[s].n_busy, tab[s].free_v, err, id, reads, writes);
            check("tab_error", err, tab[s].exp_err);
            if (!tab[s].exp_err) check("tab_job_id", id, tab[s].exp_id);
            check("tab_reads", reads, tab[s].exp_reads);
            check("tab_writes", writes, tab[s].exp_writes);
        end

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) jobs[i*32 +: 32] = $urandom;
            nb = $urandom_range(17, 0);
            fv = $urandom & 32'h7FFF_FFFF;
            s_k = -1; s_len = 0; em = $urandom_range(2, 1); rt = 1; wr_dly = 0;
            model(jobs, nb, m_err, m_reads);
            run_job(jobs, nb, fv, err, id, reads, writes);
            check("rnd_error", err, m_err);
            if (!m_err) check("rnd_job_id", id, fv[7:0]);
            check("rnd_reads", reads, m_reads);
        end

        rt = 0; s_k = -1; em = 1; wr_dly = 4;
        for (int i = 0; i < N; i++) jobs[i*32 +: 32] = $urandom;
        start_job(jobs, 0, 32'h0000_005A);
        t = 0;
        while (!w1_flag && t < 200) begin @(negedge clk); t++; end
        check("reset_reach_wr", w1_flag, 1'b1);
        @(posedge clk); #1 rst_ni = 1'b0;
        @(posedge clk); #1 rst_ni = 1'b1;
        @(negedge clk);
        check("mid_rst_req", req_o, 1'b0);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_done", done_o, 1'b0);
        check("mid_rst_error", error_o, 1'b0);
        check("mid_rst_job_id", job_id_o, 8'h00);
        check("mid_rst_add", add_o, 32'h0);
        check("mid_rst_data", data_o, 32'h0);
        check("mid_rst_wen", wen_o, 1'b1);
        repeat (6) begin
            @(negedge clk);
            check("mid_rst_quiet", {req_o, busy_o, done_o}, 3'b000);
        end
        wr_dly = 0;
        for (int i = 0; i < N; i++) jobs[i*32 +: 32] = $urandom;
        run_job(jobs, 0, 32'h0000_0033, err, id, reads, writes);
        check("restart_error", err, 1'b0);
        check("restart_job_id", id, 8'h33);
        check("restart_reads", reads, 1);
        check("restart_writes", writes, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
